// File: rtl/font_pkg.sv
// Shared font geometry, per-cell attribute bundle, fetch FSM states and the
// glyph-row attribute transform used by the character row serializer.
package font_pkg;
   localparam int CHAR_WIDTH     = 16;
   localparam int ROWS_PER_CHAR  = 20;
   localparam int CHARS          = 1024;
   localparam int RAM_WIDTH      = 15;
   localparam int COLOR_BITS     = 4;
   localparam int CHAR_CODE_BITS = $clog2(CHARS);
   localparam int ROW_BITS       = $clog2(ROWS_PER_CHAR);

   typedef struct packed {
      logic [COLOR_BITS-1:0] fg;
      logic [COLOR_BITS-1:0] bg;
      logic                  underline;
      logic                  invert;
      logic                  hidden;
   } cell_attr_t;

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_IDLE,
      ST_WAIT,
      ST_CAPTURE
   } fetch_state_t;

   // Order matters: underline is overridden by hidden, and invert applies last.
   function automatic logic [CHAR_WIDTH-1:0] apply_attr(
      input logic [CHAR_WIDTH-1:0] raw,
      input logic                  row_ok,
      input logic                  last_row,
      input cell_attr_t            attr
   );
      logic [CHAR_WIDTH-1:0] b;
      b = row_ok ? raw : '0;
      if (attr.underline && last_row) b = '1;
      if (attr.hidden) b = '0;
      if (attr.invert) b = ~b;
      return b;
   endfunction
endpackage

// File: rtl/pixel_shifter.sv
// Glyph-row shift register: emits one colour index per handshake, MSB first,
// and reports when it can take a new row (empty or finishing this cycle).
module pixel_shifter
   import font_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [CHAR_WIDTH-1:0] load_bits,
   input  logic [COLOR_BITS-1:0] load_fg,
   input  logic [COLOR_BITS-1:0] load_bg,
   output logic                  can_load,
   output logic                  pixel_valid,
   input  logic                  pixel_ready,
   output logic [COLOR_BITS-1:0] pixel_color,
   output logic                  char_done
);
   localparam int CNT_BITS = $clog2(CHAR_WIDTH);

   logic [CHAR_WIDTH-1:0] bits_q;
   logic [COLOR_BITS-1:0] fg_q;
   logic [COLOR_BITS-1:0] bg_q;
   logic [CNT_BITS-1:0]   cnt_q;
   logic                  valid_q;
   logic                  fire;
   logic                  last_px;

   assign fire        = valid_q && pixel_ready;
   assign last_px     = (cnt_q == CNT_BITS'(CHAR_WIDTH-1));
   assign can_load    = !valid_q || (fire && last_px);
   assign char_done   = fire && last_px;
   assign pixel_valid = valid_q;
   assign pixel_color = bits_q[CHAR_WIDTH-1] ? fg_q : bg_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bits_q  <= '0;
         fg_q    <= '0;
         bg_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         bits_q  <= load_bits;
         fg_q    <= load_fg;
         bg_q    <= load_bg;
         cnt_q   <= '0;
         valid_q <= 1'b1;
      end else if (fire) begin
         bits_q  <= {bits_q[CHAR_WIDTH-2:0], 1'b0};
         cnt_q   <= cnt_q + CNT_BITS'(1);
         if (last_px) valid_q <= 1'b0;
      end
   end
endmodule

// File: rtl/char_row_serializer.sv
// Font fetch pipeline plus one-entry holding register feeding the pixel
// shifter, so the next glyph row is fetched while the current one shifts out.
//
// state      | meaning
// ST_BOOT    | first cycle out of reset, not yet accepting cells
// ST_IDLE    | no fetch in flight; accepts when holding register is empty
// ST_WAIT    | font_address issued, font RAM performing its read
// ST_CAPTURE | char_row_bitmap valid, sampled and transformed this cycle
module char_row_serializer
   import font_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      char_valid,
   output logic                      char_ready,
   input  logic [CHAR_CODE_BITS-1:0] char_code,
   input  logic [ROW_BITS-1:0]       char_row,
   input  logic [COLOR_BITS-1:0]     fg,
   input  logic [COLOR_BITS-1:0]     bg,
   input  logic                      attr_underline,
   input  logic                      attr_invert,
   input  logic                      attr_hidden,
   output logic [RAM_WIDTH-1:0]      font_address,
   input  logic [CHAR_WIDTH-1:0]     char_row_bitmap,
   output logic                      pixel_valid,
   input  logic                      pixel_ready,
   output logic [COLOR_BITS-1:0]     pixel_color,
   output logic                      char_done
);
   fetch_state_t          state_q, state_d;
   logic                  accept;
   logic                  capture;
   logic [RAM_WIDTH-1:0]  font_address_q;
   cell_attr_t            cell_q;
   logic                  row_ok_q;
   logic                  last_row_q;
   logic                  row_ok;
   logic [ROW_BITS-1:0]   row_sel;
   logic [CHAR_WIDTH-1:0] capture_bits;
   logic                  hold_valid_q;
   logic [CHAR_WIDTH-1:0] hold_bits_q;
   logic [COLOR_BITS-1:0] hold_fg_q;
   logic [COLOR_BITS-1:0] hold_bg_q;
   logic                  hold_set;
   logic                  can_load;
   logic                  load;
   logic [CHAR_WIDTH-1:0] load_bits;
   logic [COLOR_BITS-1:0] load_fg;
   logic [COLOR_BITS-1:0] load_bg;

   always_comb begin
      state_d    = state_q;
      char_ready = 1'b0;
      accept     = 1'b0;
      capture    = 1'b0;
      case (state_q)
         ST_BOOT: state_d = ST_IDLE;
         ST_IDLE: begin
            char_ready = !hold_valid_q;
            if (char_valid && !hold_valid_q) begin
               accept  = 1'b1;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: state_d = ST_CAPTURE;
         ST_CAPTURE: begin
            capture = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_BOOT;
      else        state_q <= state_d;
   end

   assign row_ok  = (char_row < ROW_BITS'(ROWS_PER_CHAR));
   assign row_sel = row_ok ? char_row : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         font_address_q <= '0;
         cell_q         <= '0;
         row_ok_q       <= 1'b0;
         last_row_q     <= 1'b0;
      end else if (accept) begin
         font_address_q <= RAM_WIDTH'(32'(char_code) * 32'(ROWS_PER_CHAR) + 32'(row_sel));
         cell_q         <= '{fg: fg, bg: bg, underline: attr_underline,
                             invert: attr_invert, hidden: attr_hidden};
         row_ok_q       <= row_ok;
         last_row_q     <= (char_row == ROW_BITS'(ROWS_PER_CHAR-1));
      end
   end

   assign font_address = font_address_q;
   assign capture_bits = apply_attr(char_row_bitmap, row_ok_q, last_row_q, cell_q);

   // The holding register always drains first, so a fresh capture goes there
   // whenever it is occupied or the shifter is still busy.
   assign hold_set  = capture && (!can_load || hold_valid_q);
   assign load      = can_load && (hold_valid_q || capture);
   assign load_bits = hold_valid_q ? hold_bits_q : capture_bits;
   assign load_fg   = hold_valid_q ? hold_fg_q   : cell_q.fg;
   assign load_bg   = hold_valid_q ? hold_bg_q   : cell_q.bg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_valid_q <= 1'b0;
         hold_bits_q  <= '0;
         hold_fg_q    <= '0;
         hold_bg_q    <= '0;
      end else if (hold_set) begin
         hold_valid_q <= 1'b1;
         hold_bits_q  <= capture_bits;
         hold_fg_q    <= cell_q.fg;
         hold_bg_q    <= cell_q.bg;
      end else if (load && hold_valid_q) begin
         hold_valid_q <= 1'b0;
      end
   end

   pixel_shifter u_pixel_shifter (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .load_bits   (load_bits),
      .load_fg     (load_fg),
      .load_bg     (load_bg),
      .can_load    (can_load),
      .pixel_valid (pixel_valid),
      .pixel_ready (pixel_ready),
      .pixel_color (pixel_color),
      .char_done   (char_done)
   );
endmodule

// File: doc/char_row_serializer.md
# char_row_serializer

Pixel-generation stage directly downstream of the font lookup. Accepts one character cell per request (code, glyph row, colours, attributes), drives the font address, and captures the returned glyph row bitmap. It applies attributes and serialises the row MSB-first into one colour index per cycle under a valid/ready handshake toward the video output. A one-entry holding register overlaps the next fetch with current shifting, so a steadily fed stream produces gap-free pixels.

## Interface
- CHAR_WIDTH, 16: pixels per glyph row (bitmap width)
- ROWS_PER_CHAR, 20: glyph rows per character
- CHARS, 1024: glyphs in font; char_code width = clog2(CHARS) = 10
- RAM_WIDTH, 15: font address width
- COLOR_BITS, 4: colour index width
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- char_valid  in  1  cell request valid
- char_ready  out  1  stage can accept a cell
- char_code  in  10  glyph index
- char_row  in  5  row within glyph, 0..ROWS_PER_CHAR-1
- fg, bg  in  COLOR_BITS each  foreground/background colour
- attr_underline, attr_invert, attr_hidden  in  1 each  attributes
- font_address  out  RAM_WIDTH  to font lookup (synchronous read, 1-cycle latency)
- char_row_bitmap  in  CHAR_WIDTH  glyph row returned by font lookup
- pixel_valid  out  1  pixel_color valid
- pixel_ready  in  1  downstream consumes pixel
- pixel_color  out  COLOR_BITS  current pixel colour index
- char_done  out  1  one-cycle pulse when last pixel of a cell is consumed

## Operation
- Accept on char_valid && char_ready. Latch fg, bg, attributes, and row_ok = (char_row < ROWS_PER_CHAR).
- Register font_address = char_code*ROWS_PER_CHAR + char_row, truncated to RAM_WIDTH. If !row_ok, the address is char_code*ROWS_PER_CHAR.
- Per-cell pipeline: FETCH (address issued) -> WAIT (RAM read) -> CAPTURE (bitmap sampled).
- Bitmap transform at capture, in order:
  - b = row_ok ? char_row_bitmap : 0
  - if underline && char_row == ROWS_PER_CHAR-1, b = all ones
  - if hidden, b = 0
  - if invert, b = ~b
- At capture, the transformed row plus colours go into the shifter if it is empty or finishing this cycle; otherwise into the holding register.
- The shifter loads from the holding register when it empties.
- Shifter outputs bit CHAR_WIDTH-1 first. pixel_color = bit ? fg : bg. Advances only on pixel_valid && pixel_ready.
- char_ready = no fetch in flight && holding register empty.
- char_done pulses on the handshake of pixel index CHAR_WIDTH-1.

## Timing
- Reset values:
  - pixel_valid 0, pixel_color 0, font_address 0, char_done 0, char_ready 0
  - internal valids cleared
  - char_ready goes 1 on the first clock after reset release
- Accept at edge E0: font_address valid after E0; bitmap captured at E2; pixel_valid high after E2. Latency is 2 cycles from accept to first pixel.
- font_address holds its value until the next accept.
- pixel_color and pixel_valid remain stable while pixel_valid && !pixel_ready (no drop, no skip).
- Back-to-back: a new accept is allowed once the previous capture frees the holding slot. With pixel_ready held high and cells offered continuously, pixels are contiguous and there are no bubbles after the first.
- Reset asserted mid-operation: immediately clears all state and the in-flight fetch. The pixel stream restarts cleanly after release.

## Structure
- Shared package font_pkg: CHAR_WIDTH, ROWS_PER_CHAR, CHARS, RAM_WIDTH, COLOR_BITS, derived CHAR_CODE_BITS and ROW_BITS, and a packed cell_attr_t struct {fg, bg, underline, invert, hidden}.
- One sub-module, pixel_shifter: CHAR_WIDTH-bit shift register, pixel counter, colour mux, and handshake. The parent holds the fetch pipeline and holding register.

## Test plan
- After reset: code 0x041, row 3, fg 0xF, bg 0x1, no attrs -> font_address = 1303. With a RAM model returning 0x8001, pixels are F,1×14,F, and char_done pulses with the 16th.
- Underline on row 19 with bitmap 0x0000 -> 16 pixels of fg. Invert with bitmap 0xFF00 -> 8 bg then 8 fg. Hidden + invert -> 16 fg.
- char_row = 20 (out of range) with any bitmap -> 16 bg pixels; font_address = code*20.
- Continuous cells with pixel_ready held 1 -> exactly 16 pixel_valid cycles per cell, no gaps after the first pixel, char_ready never stalls the stream.
- pixel_ready toggled randomly (~50%) -> pixel sequence identical to the pixel_ready=1 case; pixel_color stable while stalled.
- Reset pulsed low during pixel 7 of a cell -> all outputs 0 asynchronously; after release, a new cell produces its correct full 16-pixel sequence.
